// File: rtl/redirect_ctrl.sv
// PC redirect controller: latches EX control-flow events, holds the redirect under valid/ready
// and flushes/stalls the front-end stage registers. Optional statistics counters: REDIRECT_CNT_EN.
module redirect_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_valid,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  exc_valid,
  input  logic [ADDR_WIDTH-1:0] exc_entry,
  input  logic                  ertn_valid,
  input  logic [ADDR_WIDTH-1:0] era,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  stall_req
`ifdef REDIRECT_CNT_EN
  ,
  output logic [31:0]           br_redirect_cnt,
  output logic [31:0]           exc_redirect_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_e;

  localparam logic       SINGLE_FLUSH = (FLUSH_CYCLES <= 1);
  localparam logic [3:0] DRAIN_LOAD   = 4'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  flush_q, flush_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  is_br_q, is_br_d;
  logic                  xfer;

  assign xfer = (state_q == HOLD) && valid_q && redirect_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    flush_d = flush_q;
    cnt_d   = cnt_q;
    is_br_d = is_br_q;
    case (state_q)
      IDLE: begin
        // Priority: exception, then ertn, then taken branch.
        if (exc_valid) begin
          pc_d    = exc_entry;
          is_br_d = 1'b0;
        end else if (ertn_valid) begin
          pc_d    = era;
          is_br_d = 1'b0;
        end else if (br_valid && br_taken) begin
          pc_d    = br_target;
          is_br_d = 1'b1;
        end
        if (exc_valid || ertn_valid || (br_valid && br_taken)) begin
          valid_d = 1'b1;
          flush_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (SINGLE_FLUSH) begin
            flush_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = DRAIN_LOAD;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        flush_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
      is_br_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
      is_br_q <= is_br_d;
    end
  end

  assign redirect_valid = valid_q;
  assign redirect_pc    = pc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign stall_req      = flush_q;

`ifdef REDIRECT_CNT_EN
  logic [31:0] br_cnt_q, exc_cnt_q;

  // Counted at handshake, keyed on the source latched with the redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q  <= '0;
      exc_cnt_q <= '0;
    end else if (xfer) begin
      if (is_br_q) br_cnt_q  <= br_cnt_q + 32'd1;
      else         exc_cnt_q <= exc_cnt_q + 32'd1;
    end
  end

  assign br_redirect_cnt  = br_cnt_q;
  assign exc_redirect_cnt = exc_cnt_q;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed self-checking bench for redirect_ctrl; dut1 uses FLUSH_CYCLES=1, dut3 FLUSH_CYCLES=3.
module tb_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, br_taken, exc_valid, ertn_valid, redirect_ready;
  logic [31:0] br_target, exc_entry, era;

  logic        v1, fi1, fe1, s1;
  logic [31:0] pc1;
  logic        v3, fi3, fe3, s3;
  logic [31:0] pc3;
`ifdef REDIRECT_CNT_EN
  logic [31:0] bc1, ec1, bc3, ec3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .exc_valid(exc_valid), .exc_entry(exc_entry),
    .ertn_valid(ertn_valid), .era(era),
    .redirect_ready(redirect_ready),
    .redirect_valid(v1), .redirect_pc(pc1),
    .flush_if_id(fi1), .flush_id_ex(fe1), .stall_req(s1)
`ifdef REDIRECT_CNT_EN
    , .br_redirect_cnt(bc1), .exc_redirect_cnt(ec1)
`endif
  );

  redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .exc_valid(exc_valid), .exc_entry(exc_entry),
    .ertn_valid(ertn_valid), .era(era),
    .redirect_ready(redirect_ready),
    .redirect_valid(v3), .redirect_pc(pc3),
    .flush_if_id(fi3), .flush_id_ex(fe3), .stall_req(s3)
`ifdef REDIRECT_CNT_EN
    , .br_redirect_cnt(bc3), .exc_redirect_cnt(ec3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    br_valid   = 1'b0;
    br_taken   = 1'b0;
    exc_valid  = 1'b0;
    ertn_valid = 1'b0;
  endtask

  task automatic settle();
    clear_events();
    redirect_ready = 1'b1;
    repeat (5) tick();
  endtask

  task automatic check_out1(input string tag, input logic v, input logic f);
    check({tag, "_v1"},  {31'd0, v1},  {31'd0, v});
    check({tag, "_fi1"}, {31'd0, fi1}, {31'd0, f});
    check({tag, "_fe1"}, {31'd0, fe1}, {31'd0, f});
    check({tag, "_s1"},  {31'd0, s1},  {31'd0, f});
  endtask

  task automatic check_out3(input string tag, input logic v, input logic f);
    check({tag, "_v3"},  {31'd0, v3},  {31'd0, v});
    check({tag, "_fi3"}, {31'd0, fi3}, {31'd0, f});
    check({tag, "_fe3"}, {31'd0, fe3}, {31'd0, f});
    check({tag, "_s3"},  {31'd0, s3},  {31'd0, f});
  endtask

  initial begin
    rst = 1'b0;
    clear_events();
    redirect_ready = 1'b1;
    br_target = 32'h0;
    exc_entry = 32'h1C008000;
    era       = 32'h1C000200;

    // Reset state
    repeat (2) tick();
    check_out1("rst", 1'b0, 1'b0);
    check("rst_pc1", pc1, 32'h0);
    check_out3("rst", 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check_out1("rst_rel", 1'b0, 1'b0);

    // Taken branch with ready high
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h1C000040;
    tick();
    clear_events();
    check_out1("br_n1", 1'b1, 1'b1);
    check("br_n1_pc1", pc1, 32'h1C000040);
    check_out3("br_n1", 1'b1, 1'b1);
    tick();
    check_out1("br_n2", 1'b0, 1'b0);
    check_out3("br_n2", 1'b0, 1'b1);
    tick();
    check_out3("br_n3", 1'b0, 1'b1);
    tick();
    check_out3("br_n4", 1'b0, 1'b0);
    settle();

    // Not-taken branch is not an event
    br_valid = 1'b1; br_taken = 1'b0; br_target = 32'h1C000500;
    tick();
    clear_events();
    check_out1("nt", 1'b0, 1'b0);
    settle();

    // Exception with backpressure
    redirect_ready = 1'b0;
    exc_valid = 1'b1;
    tick();
    clear_events();
    for (int i = 0; i < 4; i++) begin
      check_out1($sformatf("bp%0d", i), 1'b1, 1'b1);
      check($sformatf("bp%0d_pc1", i), pc1, 32'h1C008000);
      if (i == 3) redirect_ready = 1'b1;
      else tick();
    end
    tick();
    check_out1("bp_done", 1'b0, 1'b0);
    settle();

    // Priority: exception over ertn over branch
    exc_valid = 1'b1; ertn_valid = 1'b1;
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h1C000040;
    tick();
    clear_events();
    check("pri_all_pc1", pc1, 32'h1C008000);
    settle();
    ertn_valid = 1'b1; br_valid = 1'b1; br_taken = 1'b1;
    tick();
    clear_events();
    check("pri_ertn_pc1", pc1, 32'h1C000200);
    check_out1("pri_ertn", 1'b1, 1'b1);
    settle();

    // Ignored events in HOLD / acceptance / DRAIN (dut3)
    redirect_ready = 1'b0;
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h1C000040;
    tick();
    br_target = 32'h1C000080;
    check("ign_hold_pc3", pc3, 32'h1C000040);
    tick();
    check("ign_hold2_pc3", pc3, 32'h1C000040);
    check_out3("ign_hold2", 1'b1, 1'b1);
    redirect_ready = 1'b1;
    tick();
    check_out3("ign_d1", 1'b0, 1'b1);
    check("ign_d1_pc3", pc3, 32'h1C000040);
    tick();
    check_out3("ign_d2", 1'b0, 1'b1);
    tick();
    check_out3("ign_idle", 1'b0, 1'b0);
    check("ign_idle_pc3", pc3, 32'h1C000040);
    // Back-to-back: event in the first IDLE cycle is accepted
    tick();
    clear_events();
    check_out3("b2b", 1'b1, 1'b1);
    check("b2b_pc3", pc3, 32'h1C000080);
    settle();

    // Async reset mid-HOLD
    redirect_ready = 1'b0;
    br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h1C000100;
    tick();
    clear_events();
    check("hold_pc1", pc1, 32'h1C000100);
    #1 rst = 1'b0;
    #1;
    check_out1("arst", 1'b0, 1'b0);
    check("arst_pc1", pc1, 32'h0);
    check_out3("arst", 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    redirect_ready = 1'b1;
    tick();
    check_out1("arst_rel", 1'b0, 1'b0);

`ifdef REDIRECT_CNT_EN
    settle();
    check("cnt_rst_br1", bc1, 32'd0);
    check("cnt_rst_exc1", ec1, 32'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin
        br_valid = 1'b1; br_taken = 1'b1;
      end else if (i == 5) begin
        br_valid = 1'b1; br_taken = 1'b0;
      end else if (i < 8) begin
        exc_valid = 1'b1;
      end else begin
        ertn_valid = 1'b1;
      end
      tick();
      settle();
    end
    check("cnt_br1", bc1, 32'd5);
    check("cnt_exc1", ec1, 32'd3);
    check("cnt_br3", bc3, 32'd5);
    check("cnt_exc3", ec3, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Backward-direction control block for the in-order pipeline. Takes resolved control-flow events from the EX stage (taken branch, exception, ertn), holds a PC redirect toward IF under a valid/ready handshake, and drives flush and stall to the IF_ID and ID_EX stage registers until the redirect is accepted and the wrong-path instructions are drained. Sits between the EX stage and the fetch/stage-register control inputs.

## Interface
- `ADDR_WIDTH`, 32, width of PC and target addresses.
- `FLUSH_CYCLES`, 1, flush cycles held after redirect acceptance (legal range 1..15).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `br_valid`  in  1  EX holds a valid branch/jump this cycle.
- `br_taken`  in  1  branch resolved taken.
- `br_target`  in  ADDR_WIDTH  taken target.
- `exc_valid`  in  1  EX instruction raises an exception.
- `exc_entry`  in  ADDR_WIDTH  exception entry address (CSR eentry).
- `ertn_valid`  in  1  EX instruction is ertn.
- `era`  in  ADDR_WIDTH  return address (CSR era).
- `redirect_ready`  in  1  IF accepts redirect.
- `redirect_valid`  out  1  redirect pending.
- `redirect_pc`  out  ADDR_WIDTH  redirect address.
- `flush_if_id`  out  1  flush IF_ID register.
- `flush_id_ex`  out  1  flush ID_EX register.
- `stall_req`  out  1  freeze EX and later inputs while redirect is in flight.
- `br_redirect_cnt`, `exc_redirect_cnt`  out  32 each  statistics (only with REDIRECT_CNT_EN).

## Operation
- States: IDLE, HOLD, DRAIN. All outputs registered.
- Event detection in IDLE, priority high to low: `exc_valid` -> `exc_entry`; `ertn_valid` -> `era`; `br_valid & br_taken` -> `br_target`. `br_valid & !br_taken` is not an event.
- IDLE + event: latch target into `redirect_pc`, set `redirect_valid`, `flush_if_id`, `flush_id_ex`, `stall_req`; go to HOLD.
- HOLD: outputs held stable; `redirect_pc` must not change while `redirect_valid`=1. On `redirect_valid & redirect_ready`: clear `redirect_valid`; if FLUSH_CYCLES=1 go to IDLE (clear flush/stall), else load drain counter with FLUSH_CYCLES-1 and go to DRAIN.
- DRAIN: flush and stall stay 1; counter decrements each cycle; at counter = 1 going to 0, go to IDLE and clear flush/stall.
- Events arriving in HOLD or DRAIN belong to flushed instructions and are ignored, including an event in the acceptance cycle and in the last DRAIN cycle. First event accepted is one presented while state is IDLE.
- `redirect_pc` retains last value after acceptance (don't-care when `redirect_valid`=0).

## Timing
- Reset (async assert): state IDLE; `redirect_valid`, `flush_if_id`, `flush_id_ex`, `stall_req` = 0; `redirect_pc` = 0; counters = 0. Reset mid-HOLD/DRAIN drops the pending redirect.
- Latency: event in cycle N -> `redirect_valid`, flush, stall high from cycle N+1.
- Transfer in cycle M (valid & ready) -> `redirect_valid`=0 in M+1; flush/stall=0 in M+FLUSH_CYCLES.
- Ready already high at N+1: transfer in N+1; minimum redirect occupancy one cycle.
- `redirect_ready` may toggle arbitrarily; no combinational path from any input to any output.
- Back-to-back: earliest next event accepted is the cycle flush/stall deasserts (state IDLE).

## Configuration
- `REDIRECT_CNT_EN` defined: `br_redirect_cnt` increments on each accepted branch redirect, `exc_redirect_cnt` on each accepted exception or ertn redirect (counted at handshake), wrap modulo 2^32, reset to 0.
- Not defined: both counter ports and registers are absent from the module.

## Test plan
- Reset: `rst`=0 mid-HOLD with `redirect_pc`=0x1C000100 -> all outputs 0 immediately; after release, state IDLE and no redirect.
- Branch, ready high: `br_valid`=`br_taken`=1, `br_target`=0x1C000040 at N -> N+1 valid=1, pc=0x1C000040, flushes=1; N+2 all 0 (FLUSH_CYCLES=1).
- Backpressure: exception, entry 0x1C008000, `redirect_ready` low 3 cycles -> valid/pc/flush/stall stable 3 cycles, cleared cycle after ready.
- Priority: `exc_valid`, `ertn_valid`, taken branch same cycle, entry 0x1C008000, era 0x1C000200 -> pc=0x1C008000; ertn+branch alone -> pc=0x1C000200.
- Ignored events: taken branch to 0x1C000080 during HOLD and during DRAIN (FLUSH_CYCLES=3) -> no pc change, no extra redirect; drain lasts exactly 2 cycles past acceptance.
- With REDIRECT_CNT_EN: 5 branch + 2 exception + 1 ertn redirects -> `br_redirect_cnt`=5, `exc_redirect_cnt`=3; not-taken branch does not count.
